// File: rtl/mips_pkg.sv
// Shared encodings for the EX stage: aluop/funct constants, ALU control enum,
// control-bus bit positions and the mul/div FSM state type.
package mips_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_MFHI,
    ALU_MFLO,
    ALU_MULTU,
    ALU_DIVU,
    ALU_BAD
  } alu_ctl_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // HI/LO and mul/div functs decode as unknown when the unit is not built.
  function automatic alu_ctl_t alu_decode(input logic [1:0] aluop, input logic [5:0] funct,
                                          input logic md_en);
    alu_ctl_t ctl;
    ctl = ALU_BAD;
    case (aluop)
      ALUOP_ADD: ctl = ALU_ADD;
      ALUOP_SUB: ctl = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FN_ADD:   ctl = ALU_ADD;
          FN_SUB:   ctl = ALU_SUB;
          FN_AND:   ctl = ALU_AND;
          FN_OR:    ctl = ALU_OR;
          FN_SLT:   ctl = ALU_SLT;
          FN_MFHI:  ctl = md_en ? ALU_MFHI : ALU_BAD;
          FN_MFLO:  ctl = md_en ? ALU_MFLO : ALU_BAD;
          FN_MULTU: ctl = md_en ? ALU_MULTU : ALU_BAD;
          FN_DIVU:  ctl = md_en ? ALU_DIVU : ALU_BAD;
          default:  ctl = ALU_BAD;
        endcase
      end
      default: ctl = ALU_BAD;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/execute_stage_muldiv.sv
// Iterative MULTU (shift-add) / DIVU (restoring) unit owning HI/LO.
// Latency MD_CYCLES busy cycles after start; start is only honoured while idle.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_div,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(MD_CYCLES);

  md_state_t         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              div_q, div_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic [XLEN:0]     mul_sum, rem_sh, diff;
  logic [2*XLEN-1:0] step;

  // acc holds {partial, multiplier} for MULTU and {remainder, dividend/quotient} for DIVU.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh  = acc_q[2*XLEN-1:XLEN-1];
    diff    = rem_sh - {1'b0, opnd_q};
    if (div_q) begin
      step = diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                        : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // A zero divisor always "fits", yielding all-ones quotient and remainder = dividend.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          cnt_d   = CW'(MD_CYCLES - 1);
          div_d   = is_div;
          opnd_d  = is_div ? src_b : src_a;
          acc_d   = {{XLEN{1'b0}}, (is_div ? src_a : src_b)};
        end
      end
      MD_BUSY: begin
        acc_d = step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = MD_IDLE;
          hi_d    = step[2*XLEN-1:XLEN];
          lo_d    = step[XLEN-1:0];
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == MD_BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage with EX/MEM register; one cycle ID/EX -> EX/MEM.
// ex_stall holds the instructions behind an accepted MULTU/DIVU; mul/div built only with MULDIV_EN.
module execute_stage
  import mips_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [1:0]      wb_ctl,
  input  logic [2:0]      m_ctl,
  input  logic            regdst,
  input  logic            alusrc,
  input  logic [1:0]      aluop,
  input  logic [XLEN-1:0] npc,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  input  logic [XLEN-1:0] s_extendout,
  input  logic [4:0]      instr_2016,
  input  logic [4:0]      instr_1511,
  output logic            ex_stall,
  output logic [1:0]      wb_ctlout,
  output logic            branch,
  output logic            memread,
  output logic            memwrite,
  output logic [XLEN-1:0] add_result,
  output logic            zero,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] rdata2out,
  output logic [4:0]      five_bit_muxout
);

`ifdef MULDIV_EN
  localparam logic MD_EN = 1'b1;
`else
  localparam logic MD_EN = 1'b0;
`endif

  alu_ctl_t        ctl;
  logic [XLEN-1:0] opb, alu_out;
  logic            md_op, accept, md_busy;
  logic [XLEN-1:0] hi, lo;

  logic [1:0]      wb_q, wb_d;
  logic [2:0]      m_q, m_d;
  logic [XLEN-1:0] add_q, add_d, alu_q, alu_d, rd2_q, rd2_d;
  logic            zero_q, zero_d;
  logic [4:0]      dst_q, dst_d;

  always_comb begin
    ctl     = alu_decode(aluop, s_extendout[5:0], MD_EN);
    opb     = alusrc ? s_extendout : rdata2;
    alu_out = '0;
    case (ctl)
      ALU_ADD:  alu_out = rdata1 + opb;
      ALU_SUB:  alu_out = rdata1 - opb;
      ALU_AND:  alu_out = rdata1 & opb;
      ALU_OR:   alu_out = rdata1 | opb;
      ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, ($signed(rdata1) < $signed(opb))};
      ALU_MFHI: alu_out = hi;
      ALU_MFLO: alu_out = lo;
      default:  alu_out = '0;
    endcase
  end

  // While busy every instruction (including MFHI/MFLO) waits, which also covers the HI/LO interlock.
  assign md_op    = (ctl == ALU_MULTU) || (ctl == ALU_DIVU);
  assign accept   = md_op && !md_busy && !flush;
  assign ex_stall = md_busy | accept;

`ifdef MULDIV_EN
  muldiv_unit #(
    .XLEN      (XLEN),
    .MD_CYCLES (MD_CYCLES)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept),
    .is_div (ctl == ALU_DIVU),
    .src_a  (rdata1),
    .src_b  (rdata2),
    .busy   (md_busy),
    .hi     (hi),
    .lo     (lo)
  );
`else
  logic unused_md_cfg;
  assign md_busy       = 1'b0;
  assign hi            = '0;
  assign lo            = '0;
  assign unused_md_cfg = ^MD_CYCLES;
`endif

  // Killed or stalled slots become all-zero bubbles; mul/div and unknown ops never write back.
  always_comb begin
    wb_d   = '0;
    m_d    = '0;
    add_d  = '0;
    alu_d  = '0;
    zero_d = 1'b0;
    rd2_d  = '0;
    dst_d  = '0;
    if (!(flush || md_busy)) begin
      wb_d[WB_REGWRITE] = (ctl == ALU_BAD || md_op) ? 1'b0 : wb_ctl[WB_REGWRITE];
      wb_d[WB_MEMTOREG] = (ctl == ALU_BAD || md_op) ? 1'b0 : wb_ctl[WB_MEMTOREG];
      m_d    = m_ctl;
      add_d  = npc + (s_extendout << 2);
      alu_d  = alu_out;
      zero_d = (alu_out == '0);
      rd2_d  = rdata2;
      dst_d  = regdst ? instr_1511 : instr_2016;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_q   <= '0;
      m_q    <= '0;
      add_q  <= '0;
      alu_q  <= '0;
      zero_q <= 1'b0;
      rd2_q  <= '0;
      dst_q  <= '0;
    end else begin
      wb_q   <= wb_d;
      m_q    <= m_d;
      add_q  <= add_d;
      alu_q  <= alu_d;
      zero_q <= zero_d;
      rd2_q  <= rd2_d;
      dst_q  <= dst_d;
    end
  end

  assign wb_ctlout       = wb_q;
  assign branch          = m_q[M_BRANCH];
  assign memread         = m_q[M_MEMREAD];
  assign memwrite        = m_q[M_MEMWRITE];
  assign add_result      = add_q;
  assign zero            = zero_q;
  assign alu_result      = alu_q;
  assign rdata2out       = rd2_q;
  assign five_bit_muxout = dst_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed spot checks plus random instruction stream
// compared every cycle against a behavioural EX/MEM + HI/LO model.
module tb_execute_stage;

`ifdef MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif
  localparam int MD_CYCLES = 32;

  logic        clk = 1'b0;
  logic        rst_n, flush, regdst, alusrc;
  logic [1:0]  wb_ctl, aluop;
  logic [2:0]  m_ctl;
  logic [31:0] npc, rdata1, rdata2, s_extendout;
  logic [4:0]  instr_2016, instr_1511;
  logic        ex_stall, branch, memread, memwrite, zero;
  logic [1:0]  wb_ctlout;
  logic [31:0] add_result, alu_result, rdata2out;
  logic [4:0]  five_bit_muxout;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wb_ctl(wb_ctl), .m_ctl(m_ctl),
    .regdst(regdst), .alusrc(alusrc), .aluop(aluop), .npc(npc), .rdata1(rdata1),
    .rdata2(rdata2), .s_extendout(s_extendout), .instr_2016(instr_2016),
    .instr_1511(instr_1511), .ex_stall(ex_stall), .wb_ctlout(wb_ctlout),
    .branch(branch), .memread(memread), .memwrite(memwrite), .add_result(add_result),
    .zero(zero), .alu_result(alu_result), .rdata2out(rdata2out),
    .five_bit_muxout(five_bit_muxout)
  );

  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] add;
    logic [31:0] alu;
    logic        z;
    logic [31:0] rd2;
    logic [4:0]  dst;
  } exp_t;

  exp_t        exp_q, pend;
  int          md_left = 0, n_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic [31:0] n_hi, n_lo, n_phi, n_plo;
  logic        stall_exp = 1'b0, stall_chk = 1'b0, consumed = 1'b0, chk_en = 1'b0;
  int          vectors = 0, miscompares = 0, stall_cycles = 0;
  int          fns[10] = '{32, 34, 36, 37, 42, 16, 18, 25, 27, 63};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural view: HI/LO plus "cycles left busy"; results come from plain * / %.
  task automatic model_eval();
    logic [31:0] opb, res;
    logic [5:0]  fn;
    logic        known, md;
    exp_t        e;
    e = '0; res = '0; known = 1'b1; md = 1'b0;
    n_left = md_left; n_hi = m_hi; n_lo = m_lo; n_phi = p_hi; n_plo = p_lo;
    opb = alusrc ? s_extendout : rdata2;
    fn  = s_extendout[5:0];
    case (aluop)
      2'd0: res = rdata1 + opb;
      2'd1: res = rdata1 - opb;
      2'd2: begin
        case (fn)
          6'd32: res = rdata1 + opb;
          6'd34: res = rdata1 - opb;
          6'd36: res = rdata1 & opb;
          6'd37: res = rdata1 | opb;
          6'd42: res = ($signed(rdata1) < $signed(opb)) ? 32'd1 : 32'd0;
          6'd16: if (MD_EN) res = m_hi; else known = 1'b0;
          6'd18: if (MD_EN) res = m_lo; else known = 1'b0;
          6'd25, 6'd27: if (MD_EN) md = 1'b1; else known = 1'b0;
          default: known = 1'b0;
        endcase
      end
      default: known = 1'b0;
    endcase
    if (!known) res = '0;
    if (!rst_n) begin
      n_left = 0; n_hi = '0; n_lo = '0;
      stall_exp = 1'b0; stall_chk = 1'b0; consumed = 1'b1;
    end else begin
      stall_chk = 1'b1;
      consumed  = (md_left == 0);
      if (md_left > 0) begin
        stall_exp = 1'b1;
        n_left = md_left - 1;
        if (n_left == 0) begin n_hi = p_hi; n_lo = p_lo; end
      end else if (flush) begin
        stall_exp = 1'b0;
      end else begin
        stall_exp = md;
        if (md) begin
          n_left = MD_CYCLES;
          if (fn == 6'd25) {n_phi, n_plo} = 64'(rdata1) * 64'(rdata2);
          else if (rdata2 == 0) begin n_plo = 32'hFFFF_FFFF; n_phi = rdata1; end
          else begin n_plo = rdata1 / rdata2; n_phi = rdata1 % rdata2; end
        end
        e.wb  = (known && !md) ? wb_ctl : 2'b00;
        e.m   = m_ctl;
        e.add = npc + (s_extendout << 2);
        e.alu = res;
        e.z   = (res == 0);
        e.rd2 = rdata2;
        e.dst = regdst ? instr_1511 : instr_2016;
      end
    end
    pend = e;
  endtask

  task automatic commit();
    exp_q = pend; md_left = n_left; m_hi = n_hi; m_lo = n_lo; p_hi = n_phi; p_lo = n_plo;
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk); #1;
    commit();
  endtask

  // Present the current instruction until the stage takes it (bounded).
  task automatic run(input bit reroll);
    int  n;
    bit  done;
    n = 0; done = 1'b0;
    while (!done && n < 40) begin
      if (reroll) flush = ($urandom_range(0, 9) == 0);
      model_eval();
      done = consumed;
      @(posedge clk); #1;
      commit();
      n++;
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: instruction still held after %0d cycles, limit 40", n);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_r(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    wb_ctl = 2'b10; m_ctl = 3'b000; regdst = 1'b1; alusrc = 1'b0; aluop = 2'b10;
    npc = 32'h0; rdata1 = a; rdata2 = b; s_extendout = {26'h0, fn};
    instr_2016 = 5'd2; instr_1511 = 5'd3; flush = 1'b0;
  endtask

  task automatic rand_ins();
    int k;
    wb_ctl = 2'($urandom); m_ctl = 3'($urandom);
    regdst = 1'($urandom); alusrc = ($urandom_range(0, 3) == 0);
    aluop = 2'($urandom_range(0, 2));
    npc = $urandom;
    rdata1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
    rdata2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
    if ($urandom_range(0, 4) == 0) rdata2 = rdata1;
    if ($urandom_range(0, 7) == 0) rdata2 = '0;
    s_extendout = $urandom;
    if (aluop == 2'b10) begin
      k = $urandom_range(0, 10);
      if (k < 10) s_extendout[5:0] = 6'(fns[k]);
    end
    instr_2016 = 5'($urandom); instr_1511 = 5'($urandom);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("wb_ctlout", wb_ctlout, exp_q.wb);
      check("m_ctl_out", {branch, memread, memwrite}, exp_q.m);
      check("add_result", add_result, exp_q.add);
      check("alu_result", alu_result, exp_q.alu);
      check("zero", zero, exp_q.z);
      check("rdata2out", rdata2out, exp_q.rd2);
      check("five_bit_muxout", five_bit_muxout, exp_q.dst);
      if (stall_chk) check("ex_stall", ex_stall, stall_exp);
      if (ex_stall === 1'b1) stall_cycles++;
    end
  end

  initial begin
    int s0;
    set_r(6'd32, 32'd0, 32'd0);
    aluop = 2'b00;
    do_reset();
    chk_en = 1'b1;
    check("reset_alu_result", alu_result, 32'd0);
    check("reset_wb_ctlout", wb_ctlout, 2'b00);
    check("reset_ex_stall", ex_stall, 1'b0);

    // ADD 5+7 into rd=9
    set_r(6'd32, 32'd5, 32'd7); instr_1511 = 5'd9;
    run(1'b0);
    check("t1_alu", alu_result, 32'd12);
    check("t1_zero", zero, 1'b0);
    check("t1_dst", five_bit_muxout, 5'd9);

    // SUB equal operands, branch target npc + imm*4
    set_r(6'd3, 32'h1234, 32'h1234); aluop = 2'b01; m_ctl = 3'b100; npc = 32'h100;
    run(1'b0);
    check("t2_zero", zero, 1'b1);
    check("t2_add_result", add_result, 32'h10C);
    check("t2_branch", branch, 1'b1);

    // MULTU 0xFFFFFFFF*2 then MFLO, MFHI
    s0 = stall_cycles;
    set_r(6'd25, 32'hFFFF_FFFF, 32'd2); run(1'b0);
    check("t3_multu_wb", wb_ctlout, 2'b00);
    set_r(6'd18, 32'd0, 32'd0); run(1'b0);
    check("t3_stall_cycles", 32'(stall_cycles - s0), MD_EN ? 32'd33 : 32'd0);
    check("t3_mflo", alu_result, MD_EN ? 32'hFFFF_FFFE : 32'd0);
    set_r(6'd16, 32'd0, 32'd0); run(1'b0);
    check("t3_mfhi", alu_result, MD_EN ? 32'd1 : 32'd0);

    // MULTU killed in its accept cycle
    s0 = stall_cycles;
    set_r(6'd25, 32'd5, 32'd5); m_ctl = 3'b110; flush = 1'b1; run(1'b0);
    check("t5_stall_cycles", 32'(stall_cycles - s0), 32'd0);
    check("t5_bubble_m", {branch, memread, memwrite}, 3'b000);
    set_r(6'd16, 32'd0, 32'd0); run(1'b0);
    check("t5_mfhi_kept", alu_result, MD_EN ? 32'd1 : 32'd0);

    // DIVU by zero and by 7
    set_r(6'd27, 32'd100, 32'd0); run(1'b0);
    set_r(6'd18, 32'd0, 32'd0); run(1'b0);
    check("t4_div0_lo", alu_result, MD_EN ? 32'hFFFF_FFFF : 32'd0);
    set_r(6'd16, 32'd0, 32'd0); run(1'b0);
    check("t4_div0_hi", alu_result, MD_EN ? 32'd100 : 32'd0);
    set_r(6'd27, 32'd100, 32'd7); run(1'b0);
    set_r(6'd18, 32'd0, 32'd0); run(1'b0);
    check("t4_div7_lo", alu_result, MD_EN ? 32'd14 : 32'd0);
    set_r(6'd16, 32'd0, 32'd0); run(1'b0);
    check("t4_div7_hi", alu_result, MD_EN ? 32'd2 : 32'd0);

    // Reset while busy abandons the divide and clears HI/LO
    set_r(6'd27, 32'd1000, 32'd3); run(1'b0);
    set_r(6'd16, 32'd0, 32'd0);
    repeat (5) tick();
    do_reset();
    check("t6_alu_after_rst", alu_result, 32'd0);
    check("t6_wb_after_rst", wb_ctlout, 2'b00);
    check("t6_stall_after_rst", ex_stall, 1'b0);
    run(1'b0);
    check("t6_mfhi_zero", alu_result, 32'd0);

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      rand_ins();
      run(1'b1);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
